// File: rtl/rr_arb2_pkg.sv
// rr_arb2_pkg: shared types and constants for the two-source registered arbiter.
// Rev 1.0
`default_nettype none

package rr_arb2_pkg;

    localparam int RR_ARB2_WIDTH = 4;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2_pick.sv
// rr_arb2_pick: combinational grant selection for two sources.
// Contention policy: round-robin with RR_ARB2_ROUND_ROBIN_EN, else A wins. Rev 1.0
`default_nettype none

module rr_arb2_pick
    import rr_arb2_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic last_grant,
    input  logic accept,
    output logic grant_a,
    output logic grant_b
);

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (accept) begin
            if (a_valid && b_valid) begin
`ifdef RR_ARB2_ROUND_ROBIN_EN
                // Contention goes to whichever source did not win last time.
                grant_a = (last_grant == SEL_B);
                grant_b = (last_grant == SEL_A);
`else
                grant_a = 1'b1;
`endif
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

`ifndef RR_ARB2_ROUND_ROBIN_EN
    logic w_unused_last;
    assign w_unused_last = last_grant;
`endif

endmodule

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2: two-source arbiter feeding a one-deep output register, full throughput.
// Optional macro RR_ARB2_ROUND_ROBIN_EN selects round-robin contention. Rev 1.0
`default_nettype none

module rr_arb2
    import rr_arb2_pkg::*;
#(
    parameter int WIDTH = RR_ARB2_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_last_grant;
    logic             w_accept;
    logic             w_grant_a;
    logic             w_grant_b;

    // Gating with rst_n keeps both readies low for the whole reset window.
    assign w_accept = rst_n && ((r_state == EMPTY) || y_ready);

    rr_arb2_pick u_pick (
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .last_grant (r_last_grant),
        .accept     (w_accept),
        .grant_a    (w_grant_a),
        .grant_b    (w_grant_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant_a || w_grant_b) begin
            w_state_nxt = FULL;
        end else if ((r_state == FULL) && y_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    always_comb begin
        y_valid = (r_state == FULL);
        a_ready = w_grant_a;
        b_ready = w_grant_b;
        if (w_grant_a) begin
            sel = SEL_A;
        end else if (w_grant_b) begin
            sel = SEL_B;
        end else begin
            sel = r_last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_last_grant <= SEL_B;
        end else begin
            if (w_grant_a) begin
                r_data       <= a_data;
                r_last_grant <= SEL_A;
            end else if (w_grant_b) begin
                r_data       <= b_data;
                r_last_grant <= SEL_B;
            end
        end
    end

    assign y_data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb2.sv
// tb_rr_arb2: directed and random checks of rr_arb2 against a transaction-level model.
// Rev 1.0
`default_nettype none

module tb_rr_arb2;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         a_valid;
    logic [W-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [W-1:0] b_data;
    logic         b_ready;
    logic         sel;
    logic         y_valid;
    logic [W-1:0] y_data;
    logic         y_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Model: occupancy of the output slot, its word, and who won last.
    bit           m_full;
    logic [W-1:0] m_data;
    int           m_last;

    rr_arb2 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .sel     (sel),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner index: -1 none, 0 A, 1 B.
    function automatic int model_winner();
        bit acc;
        acc = !m_full || y_ready;
        if (!acc) return -1;
        if (a_valid && b_valid) begin
`ifdef RR_ARB2_ROUND_ROBIN_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_last = 1;
    endtask

    // Drive one cycle's inputs, check all outputs mid-cycle, then advance one edge.
    task automatic step(input logic av, input logic [W-1:0] ad,
                        input logic bv, input logic [W-1:0] bd, input logic yr);
        int win;
        a_valid = av; a_data = ad;
        b_valid = bv; b_data = bd;
        y_ready = yr;
        #1;
        win = model_winner();
        check("a_ready", a_ready, win == 0);
        check("b_ready", b_ready, win == 1);
        check("sel", sel, (win >= 0) ? win : m_last);
        check("y_valid", y_valid, m_full);
        check("y_data", y_data, m_data);
        @(posedge clk);
        if (win == 0) begin
            m_full = 1'b1; m_data = ad; m_last = 0;
        end else if (win == 1) begin
            m_full = 1'b1; m_data = bd; m_last = 1;
        end else if (m_full && yr) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        y_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_sel", sel, 1);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lone A: immediate grant, word appears one cycle later.
        a_valid = 1'b1; a_data = 4'b0110; y_ready = 1'b1;
        #1;
        check("d_lone_a_ready", a_ready, 1);
        check("d_lone_sel", sel, 0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        #1;
        check("d_lone_y_valid", y_valid, 1);
        check("d_lone_y_data", y_data, 4'b0110);
        m_full = 1'b1; m_data = 4'b0110; m_last = 0;

        // Drain with nothing offered: slot empties, word held.
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        check("d_drain_y_valid", y_valid, 0);
        check("d_drain_y_data", y_data, 4'b0110);

        // Sustained contention with the consumer always ready.
        repeat (6) step(1'b1, 4'b0110, 1'b1, 4'b0101, 1'b1);

        // Load 0101 from B, then stall three cycles with A offering.
        step(1'b0, 4'h0, 1'b1, 4'b0101, 1'b1);
        repeat (3) begin
            step(1'b1, 4'b0110, 1'b0, 4'h0, 1'b0);
            check("d_stall_y_data", y_data, 4'b0101);
        end
        step(1'b1, 4'b0110, 1'b0, 4'h0, 1'b1);
        check("d_unstall_y_data", y_data, 4'b0110);

        // Asynchronous reset in the middle of a cycle while FULL.
        check("d_prereset_full", y_valid, 1);
        a_valid = 1'b1; b_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("d_arst_y_valid", y_valid, 0);
        check("d_arst_y_data", y_data, 0);
        check("d_arst_a_ready", a_ready, 0);
        check("d_arst_b_ready", b_ready, 0);
        check("d_arst_sel", sel, 1);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // First contention after reset goes to A.
        step(1'b1, 4'h3, 1'b1, 4'hc, 1'b1);
        check("d_post_rst_win", y_data, 4'h3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), W'($urandom),
                 ($urandom_range(0, 3) != 0), W'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
